quiz_buzz_arbiter: RTL
======================

Name: quiz_buzz_arbiter

Overview:
- Upstream control stage for the quiz countdown timer.
- Debounces the host buttons and four contestant buzz-in keys, and runs the round state machine.
- Decides the first valid buzz-in by fixed priority and detects false starts.
- Drives the countdown timer's start level and reload pulse, and consumes its time-up indication.

Parameters:
DEB_CYCLES, 20'd500_000, consecutive stable CLK cycles needed to accept a key level change (10 ms at 50 MHz)
BUZZ_CYCLES, 24'd5_000_000, length of the Buzzer_Win pulse in CLK cycles (100 ms at 50 MHz)

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
Host_Start  input  1  host "begin round" button, active-high, raw
Host_Clear  input  1  host "clear round" button, active-high, raw
Player_Key  input  4  contestant buttons, active-low, raw; bit0 = player 1
Time_Up  input  1  level from timer stage, high when count has reached 00
Timer_Start  output  1  level to timer stage; high = count running/holding
Timer_Load_n  output  1  active-low one-cycle pulse that reloads the timer to 30
Winner  output  3  0 = none, 1..4 = winning player number
Player_LED  output  4  one-hot winner lamp; bit0 = player 1
Foul  output  1  high while in FOUL state
Foul_Player  output  3  0 = none, 1..4 = false-starting player
Buzzer_Win  output  1  high for BUZZ_CYCLES after a win is registered
State  output  3  FSM state code, for display/debug

Behaviour:
- Reset (async, RSTn low): state IDLE.
  - Outputs: Timer_Start 0, Timer_Load_n 1, Winner 0, Player_LED 0, Foul 0, Foul_Player 0, Buzzer_Win 0.
  - Synchronizers, debounce counters and the buzz counter clear to 0. Debounced key levels clear to "released".
- Input conditioning, per raw input (6 total):
  - Two-flop synchronizer.
  - Per-input counter: when the synchronized level differs from the debounced level, count up; accept the new level when the count reaches DEB_CYCLES-1. Any mismatch gap resets the count to 0.
  - Host buttons act on the rising edge of the debounced pressed level (one-cycle event).
  - Player keys act on the debounced pressed level (level, active after inversion).
  - Latency from a stable raw press to action: 2 + DEB_CYCLES + 1 CLK.
- State codes: IDLE=0, ARMED=1, ANSWER=2, TIMEOUT=3, FOUL=4.
- Transitions, evaluated each CLK:
  - Host_Clear event: from any state go to IDLE. Clears Winner, Player_LED, Foul, Foul_Player, Timer_Start and Buzzer_Win. Takes priority over every other event in the same cycle.
  - IDLE + Host_Start event: go to ARMED. Timer_Load_n is 0 for exactly that one cycle.
  - IDLE + any player pressed, no Host_Start event: go to FOUL. Foul_Player = lowest-numbered pressed player.
  - IDLE + Host_Start event and a player pressed in the same cycle: Host_Start wins; go to ARMED.
  - ARMED + any player pressed: go to ANSWER.
    - Winner = lowest-numbered pressed player; fixed priority 1>2>3>4 for simultaneous presses.
    - Player_LED is one-hot; Timer_Start goes to 1 in the same cycle Winner updates.
    - The buzz counter loads and Buzzer_Win goes high.
  - ANSWER: further presses and Host_Start are ignored. Time_Up high goes to TIMEOUT.
  - TIMEOUT: Timer_Start stays 1 (timer holds 00) and Winner is held. Exits only on Host_Clear.
  - FOUL: Foul=1. Player presses and Host_Start are ignored. Exits only on Host_Clear.
- Buzzer_Win stays high for exactly BUZZ_CYCLES cycles, independent of state, unless cut short by Host_Clear or reset.
- Time_Up is ignored outside ANSWER.
- Reset mid-round aborts immediately to reset values. No reload pulse is issued.

Test Plan:
Set DEB_CYCLES=4 and BUZZ_CYCLES=8 for all scenarios.
1. Reset, then Host_Start held 10 cycles → Timer_Load_n low exactly 1 cycle, State=1, Timer_Start=0.
2. From ARMED, Player_Key=4'b1011 (player 3) held 10 cycles → Winner=3, Player_LED=4'b0100, Timer_Start=1, Buzzer_Win high exactly 8 cycles.
3. From ARMED, Player_Key=4'b0101 (players 2 and 4) pressed in the same cycle → Winner=2, Player_LED=4'b0010; a later press of player 1 leaves Winner=2.
4. From IDLE, player 4 pressed → State=4, Foul=1, Foul_Player=4, Timer_Start=0; Host_Clear → State=0, Foul=0, Foul_Player=0.
5. In ANSWER, raise Time_Up → State=3, Timer_Start stays 1, Winner held; Host_Start ignored; Host_Clear → all outputs at reset values.
6. Player 1 key bouncing (low 2 cycles, high 1, low 2) then stable low 6 cycles in ARMED → no win during the bounce; Winner=1 after 2+4+1 cycles of stable low. Separately, pulse RSTn low in ANSWER → all outputs return to reset values immediately.

Source files
------------

// File: rtl/quiz_buzz_arbiter.sv
// Quiz round control stage: debounces the host buttons and the four
// contestant keys, runs the round FSM, picks the first buzz-in by fixed
// priority (player 1 highest), flags false starts, and drives the
// countdown timer's start level and reload pulse.
module quiz_buzz_arbiter #(
  parameter logic [19:0] DEB_CYCLES  = 20'd500_000,
  parameter logic [23:0] BUZZ_CYCLES = 24'd5_000_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Host_Start,
  input  logic       Host_Clear,
  input  logic [3:0] Player_Key,
  input  logic       Time_Up,
  output logic       Timer_Start,
  output logic       Timer_Load_n,
  output logic [2:0] Winner,
  output logic [3:0] Player_LED,
  output logic       Foul,
  output logic [2:0] Foul_Player,
  output logic       Buzzer_Win,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_ANSWER  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_FOUL    = 3'd4
  } state_t;

  // All six inputs as "pressed" levels: bit0 start, bit1 clear, bits5:2 players.
  // Player keys are inverted before synchronizing so that 0 means released
  // everywhere in the conditioning chain.
  logic [5:0]       raw_pressed;
  logic [5:0]       sync1, sync2;
  logic [5:0]       deb, deb_q;
  logic [5:0][19:0] deb_cnt;

  assign raw_pressed = {~Player_Key, Host_Clear, Host_Start};

  // Two-flop synchronizers plus per-input debounce counters.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_q   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw_pressed;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_CYCLES - 20'd1) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Host buttons act on a one-cycle rising edge; players act on level.
  logic       start_ev, clear_ev, any_pressed;
  logic [3:0] pressed;
  logic [2:0] first_player;

  assign start_ev    = deb[0] & ~deb_q[0];
  assign clear_ev    = deb[1] & ~deb_q[1];
  assign pressed     = deb[5:2];
  assign any_pressed = |pressed;

  // Fixed priority encoder: lowest-numbered pressed player wins.
  always_comb begin
    first_player = 3'd0;
    if      (pressed[0]) first_player = 3'd1;
    else if (pressed[1]) first_player = 3'd2;
    else if (pressed[2]) first_player = 3'd3;
    else if (pressed[3]) first_player = 3'd4;
  end

  state_t state, state_next;
  logic   enter_armed, enter_answer, enter_foul;

  // Clear has priority over every other event, so it masks all entries.
  assign enter_armed  = (state == ST_IDLE)  && start_ev && !clear_ev;
  assign enter_foul   = (state == ST_IDLE)  && !start_ev && any_pressed && !clear_ev;
  assign enter_answer = (state == ST_ARMED) && any_pressed && !clear_ev;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (clear_ev) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enter_armed)     state_next = ST_ARMED;
          else if (enter_foul) state_next = ST_FOUL;
        end
        ST_ARMED:   if (enter_answer) state_next = ST_ANSWER;
        ST_ANSWER:  if (Time_Up)      state_next = ST_TIMEOUT;
        ST_TIMEOUT: state_next = ST_TIMEOUT;
        ST_FOUL:    state_next = ST_FOUL;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  logic [2:0]  winner_q, foul_player_q;
  logic        load_n_q;
  logic [23:0] buzz_cnt;

  // Round data: winner/foul latches, reload pulse and buzzer countdown.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      winner_q      <= 3'd0;
      foul_player_q <= 3'd0;
      load_n_q      <= 1'b1;
      buzz_cnt      <= '0;
    end else begin
      load_n_q <= !enter_armed;
      if (clear_ev) begin
        winner_q      <= 3'd0;
        foul_player_q <= 3'd0;
        buzz_cnt      <= '0;
      end else begin
        if (enter_answer) winner_q      <= first_player;
        if (enter_foul)   foul_player_q <= first_player;
        if (enter_answer)         buzz_cnt <= BUZZ_CYCLES;
        else if (buzz_cnt != '0)  buzz_cnt <= buzz_cnt - 24'd1;
      end
    end
  end

  // Outputs decoded from state and round data.
  always_comb begin
    Timer_Start  = (state == ST_ANSWER) || (state == ST_TIMEOUT);
    Foul         = (state == ST_FOUL);
    State        = state;
    Winner       = winner_q;
    Foul_Player  = foul_player_q;
    Timer_Load_n = load_n_q;
    Buzzer_Win   = (buzz_cnt != '0);
    case (winner_q)
      3'd1:    Player_LED = 4'b0001;
      3'd2:    Player_LED = 4'b0010;
      3'd3:    Player_LED = 4'b0100;
      3'd4:    Player_LED = 4'b1000;
      default: Player_LED = 4'b0000;
    endcase
  end

endmodule
